// File: rtl/flappy_pkg.sv
// +-------------------------------------------------------------------+
// | flappy_pkg : shared game-state encoding and playfield geometry     |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } game_state_t;

    localparam int SCREEN_H = 480;
    localparam int BIRD_H   = 16;
    localparam int Y_FLOOR  = SCREEN_H - BIRD_H;
    localparam int Y_W      = 10;
    localparam int V_W      = 8;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// +-------------------------------------------------------------------+
// | btn_debounce : sample-enabled shift-register debouncer with press  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_N = 4
) (
    input  logic clock_in,
    input  logic rst,
    input  logic sample_en,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    logic [DEBOUNCE_N-1:0] r_shift;
    logic [DEBOUNCE_N-1:0] w_shift_next;
    logic                  w_level_next;

    // Level is judged on the post-shift window so a press lands in the sampling cycle.
    always_comb begin
        w_shift_next = {r_shift[DEBOUNCE_N-2:0], btn_raw};
        w_level_next = level;
        if (&w_shift_next)
            w_level_next = 1'b1;
        else if (~|w_shift_next)
            w_level_next = 1'b0;
        press = sample_en & w_level_next & ~level;
    end

    always_ff @(posedge clock_in) begin
        if (!rst) begin
            r_shift <= '0;
            level   <= 1'b0;
        end else if (sample_en) begin
            r_shift <= w_shift_next;
            level   <= w_level_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bird_physics.sv
// +-------------------------------------------------------------------+
// | bird_physics : tick edges, flap latch, game FSM and bird dynamics  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module bird_physics #(
    parameter int Y_W        = flappy_pkg::Y_W,
    parameter int V_W        = flappy_pkg::V_W,
    parameter int SCREEN_H   = flappy_pkg::SCREEN_H,
    parameter int BIRD_H     = flappy_pkg::BIRD_H,
    parameter int Y_START    = 232,
    parameter int GRAVITY    = 1,
    parameter int FLAP_V     = -8,
    parameter int V_MAX      = 8,
    parameter int DEBOUNCE_N = 4
) (
    input  logic                  clock_in,
    input  logic                  rst,
    input  logic                  clk_game,
    input  logic                  clk_fast,
    input  logic                  btn_flap,
    input  logic                  collide,
    output logic [Y_W-1:0]        bird_y,
    output logic signed [V_W-1:0] bird_vel,
    output logic [1:0]            game_state,
    output logic                  frame_tick,
    output logic                  hit_ground
);
    import flappy_pkg::*;

    localparam int YS      = Y_W + 2;
    localparam int FLOOR_Y = SCREEN_H - BIRD_H;
    localparam logic signed [V_W:0]   C_V_MAX  = (V_W+1)'(V_MAX);
    localparam logic signed [V_W-1:0] C_FLAP_V = V_W'(FLAP_V);

    game_state_t           r_state, w_state_next;
    logic                  r_game_q, r_fast_q, r_pending;
    logic                  w_game_tick, w_fast_tick, w_press, w_level;
    logic signed [V_W:0]   w_vel_inc;
    logic signed [V_W-1:0] w_v_new, w_vel_next;
    logic [YS-1:0]         w_y_new;
    logic [Y_W-1:0]        w_y_next;
    logic                  w_ceil, w_floor, w_hit_next, w_run_update;

    assign w_game_tick = clk_game & ~r_game_q;
    assign w_fast_tick = clk_fast & ~r_fast_q;
    assign game_state  = r_state;

    btn_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_debounce (
        .clock_in  (clock_in),
        .rst       (rst),
        .sample_en (w_fast_tick),
        .btn_raw   (btn_flap),
        .level     (w_level),
        .press     (w_press)
    );

    // Signed position in two extra bits so ceiling underflow and floor overshoot are visible.
    always_comb begin
        w_vel_inc = {bird_vel[V_W-1], bird_vel} + (V_W+1)'(GRAVITY);
        w_v_new   = r_pending ? C_FLAP_V
                  : (w_vel_inc > C_V_MAX) ? C_V_MAX[V_W-1:0] : w_vel_inc[V_W-1:0];
        w_y_new   = {2'b00, bird_y} + {{(YS-V_W){w_v_new[V_W-1]}}, w_v_new};
        w_ceil    = w_y_new[YS-1] | (w_y_new == '0);
        w_floor   = ~w_y_new[YS-1] & (w_y_new >= YS'(FLOOR_Y));
    end

    always_comb begin
        w_state_next = r_state;
        w_y_next     = bird_y;
        w_vel_next   = bird_vel;
        w_hit_next   = 1'b0;
        w_run_update = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_y_next   = Y_W'(Y_START);
                w_vel_next = '0;
                if (w_game_tick && r_pending)
                    w_run_update = 1'b1;
            end
            RUN: begin
                if (w_game_tick)
                    w_run_update = 1'b1;
            end
            DEAD: begin
                if (w_game_tick && r_pending) begin
                    w_state_next = IDLE;
                    w_y_next     = Y_W'(Y_START);
                    w_vel_next   = '0;
                end
            end
            default: w_state_next = IDLE;
        endcase

        if (w_run_update) begin
            w_state_next = RUN;
            if (w_ceil) begin
                w_y_next   = '0;
                w_vel_next = '0;
            end else if (w_floor) begin
                w_y_next     = Y_W'(FLOOR_Y);
                w_vel_next   = '0;
                w_state_next = DEAD;
                w_hit_next   = 1'b1;
            end else begin
                w_y_next   = w_y_new[Y_W-1:0];
                w_vel_next = w_v_new;
            end
            if (collide)
                w_state_next = DEAD;
        end
    end

    // A press in the consuming cycle re-arms the latch; set beats clear.
    always_ff @(posedge clock_in) begin
        if (!rst) begin
            r_game_q   <= 1'b0;
            r_fast_q   <= 1'b0;
            r_pending  <= 1'b0;
            r_state    <= IDLE;
            bird_y     <= Y_W'(Y_START);
            bird_vel   <= '0;
            frame_tick <= 1'b0;
            hit_ground <= 1'b0;
        end else begin
            r_game_q   <= clk_game;
            r_fast_q   <= clk_fast;
            r_pending  <= w_press | (r_pending & ~w_game_tick);
            r_state    <= w_state_next;
            bird_y     <= w_y_next;
            bird_vel   <= w_vel_next;
            frame_tick <= w_game_tick;
            hit_ground <= w_hit_next;
        end
    end

endmodule

`default_nettype wire

// File: doc/bird_physics.md
# bird_physics

Game-logic stage directly downstream of the clock divider. Turns the divider's `clk_game` (50 Hz) and `clk_fast` (500 Hz) square-wave outputs into single-cycle enables. Debounces the flap button on fast ticks and updates the bird's vertical position and velocity once per game tick. Feeds the renderer and scoring logic with `bird_y`, the game state and a post-update `frame_tick`.

## Interface
- `Y_W`, 10, width of bird_y (unsigned pixels)
- `V_W`, 8, width of bird_vel (signed, pixels/tick)
- `SCREEN_H`, 480, playfield height in pixels
- `BIRD_H`, 16, bird sprite height; floor limit `Y_FLOOR = SCREEN_H - BIRD_H` (464)
- `Y_START`, 232, bird_y in IDLE and after reset
- `GRAVITY`, 1, velocity increment per game tick
- `FLAP_V`, -8, velocity loaded on a flap
- `V_MAX`, 8, terminal (downward) velocity
- `DEBOUNCE_N`, 4, consecutive equal fast-tick samples to accept a button level

Ports:
- `clock_in` in 1: 100 MHz system clock; the only clock.
- `rst` in 1: synchronous, active-low reset.
- `clk_game` in 1: divider output, treated as a data level (same clock domain), not a clock.
- `clk_fast` in 1: divider output, treated as a data level.
- `btn_flap` in 1: raw flap button, active-high.
- `collide` in 1: pipe-collision flag from the pipe logic, sampled only on game ticks.
- `bird_y` out Y_W: top edge of the bird; reset value Y_START.
- `bird_vel` out V_W signed: current velocity; reset value 0.
- `game_state` out 2: 0 = IDLE, 1 = RUN, 2 = DEAD; reset value IDLE.
- `frame_tick` out 1: one-cycle pulse, one cycle after each physics update; reset value 0.
- `hit_ground` out 1: one-cycle pulse coincident with `frame_tick` on floor impact; reset value 0.

## Operation
- **Tick generation.** Register `clk_game` and `clk_fast` into `_q` copies.
  - `game_tick = clk_game & ~clk_game_q`.
  - `fast_tick = clk_fast & ~clk_fast_q`.
  - Only rising edges count.
- **Debounce.**
  - On each fast_tick, shift `btn_flap` into a DEBOUNCE_N-bit register.
  - The debounced level becomes 1 when the register is all ones and 0 when it is all zeros; otherwise it holds.
  - A 0→1 transition of the debounced level raises `flap_pending`.
- **flap_pending.** Sticky. Cleared by the game_tick that consumes it, in any state. A new press on the same cycle as the consuming tick re-sets it (set wins).
- **IDLE.**
  - bird_y = Y_START, bird_vel = 0.
  - On game_tick with flap_pending: move to RUN and apply the RUN update in that same tick, as a flap.
- **RUN, on game_tick:**
  - `v' = flap_pending ? FLAP_V : min(bird_vel + GRAVITY, V_MAX)`.
  - `y' = bird_y + v'`, computed signed in Y_W+2 bits.
  - If `y' <= 0`: bird_y = 0, bird_vel = 0; stay in RUN.
  - Else if `y' >= Y_FLOOR`: bird_y = Y_FLOOR, bird_vel = 0; go to DEAD and pulse hit_ground.
  - Else: bird_y = y', bird_vel = v'.
  - If `collide`: go to DEAD. The position update still applies. hit_ground pulses only if the floor was also reached.
- **DEAD.**
  - Outputs frozen.
  - On game_tick with flap_pending: go to IDLE, bird_y = Y_START, bird_vel = 0.
- **Game-tick coverage.** frame_tick pulses after every game_tick in every state.
- **Reset.** Low rst at a clock edge, in any state or mid-debounce, restores all reset values. It also clears the debounce shift register, the debounced level, flap_pending and both `_q` registers.

## Timing
- game_tick is high in the first cycle in which `clk_game` is sampled at 1. State, bird_y and bird_vel update at the end of that cycle.
- frame_tick and hit_ground are high in the following cycle, when the new values are visible. Latency from clk_game rising to frame_tick is 2 cycles.
- Press-to-pending latency: DEBOUNCE_N fast ticks plus 1 cycle.
- game_tick and fast_tick in the same cycle: debounce updates first conceptually. A press completed in that cycle is not consumed by that game_tick.
- Back-to-back game ticks are impossible (minimum 2 cycles apart); the design need not handle them.

## Structure
- Package `flappy_pkg`:
  - `game_state_t` enum (IDLE, RUN, DEAD).
  - SCREEN_H, BIRD_H, Y_FLOOR, Y_W, V_W defaults.
- Sub-module `btn_debounce`:
  - Inputs: clock_in, rst, sample enable (fast_tick), raw button.
  - Outputs: debounced level and rising-edge press pulse.
  - Parameter: DEBOUNCE_N.
- Top: edge detectors, flap_pending, state machine and physics datapath.

## Test plan
- Reset low for 3 cycles, then high with no ticks → bird_y=232, bird_vel=0, game_state=0, frame_tick=0 indefinitely.
- IDLE, btn_flap high for 4 fast ticks, then a game tick → game_state=1, bird_y=224, bird_vel=-8. Next tick without a flap → bird_y=217, bird_vel=-7.
- RUN at y=232, vel=0, no flaps → vel 1..8 and y 233, 235, 238, …, 268 after 8 ticks, then +8 per tick (276, 284).
- Fall to the floor → bird_y clamps at 464, game_state=2, hit_ground and frame_tick both high for exactly one cycle. Further ticks change nothing until a flap, which gives IDLE with y=232.
- btn_flap high for 3 fast ticks, then low, then high 4 ticks → only one flap_pending. Ceiling case: y=4, flap → bird_y=0, bird_vel=0, still RUN.
- collide=1 on a RUN tick at y=100 vel=2 → DEAD, bird_y=103, no hit_ground. rst low mid-RUN → next cycle all reset values, pending flap discarded.
